// File: rtl/fifo_share_sched.sv
// Round-robin scheduler sharing one 64x16 FIFO between two writers and one reader.
// Push: same-cycle grant. Pop: grant at T, rd_valid at T+2. Requests are levels that wait for a grant.
// Backpressure: writers stall on full, the reader stalls on empty, and no grants issue in the readout cycle.
module fifo_share_sched #(
    parameter int DEPTH = 64,
    parameter int DW    = 16,
    parameter int CW    = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    wr_req,
    input  logic [DW-1:0] wr_data0,
    input  logic [DW-1:0] wr_data1,
    output logic [1:0]    wr_gnt,
    input  logic          rd_req,
    output logic          rd_gnt,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          fifo_push,
    output logic          fifo_pop,
    output logic [DW-1:0] fifo_din,
    input  logic          fifo_empty,
    input  logic          fifo_full,
    input  logic          fifo_error,
    input  logic [DW-1:0] ram_q,
    output logic [CW-1:0] count,
    input  logic          err_clr,
    output logic          err_sticky
);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t     state, state_nxt;
    logic [1:0] rr_ptr, rr_ptr_nxt;
    logic [2:0] elig, gnt;
    logic       cnt_zero, cnt_full, flag_err;

    assign cnt_zero = (count == '0);
    assign cnt_full = (count == CW'(DEPTH));

    // Requester index 0=wr0, 1=wr1, 2=rd; gating on rst keeps every grant low during reset.
    always_comb begin
        elig = '0;
        if (!rst && state == IDLE) begin
            elig[0] = wr_req[0] && !fifo_full && !cnt_full;
            elig[1] = wr_req[1] && !fifo_full && !cnt_full;
            elig[2] = rd_req && !fifo_empty && !cnt_zero;
        end
    end

    always_comb begin
        gnt = '0;
        case (rr_ptr)
            2'd0: begin
                if (elig[0])      gnt = 3'b001;
                else if (elig[1]) gnt = 3'b010;
                else if (elig[2]) gnt = 3'b100;
            end
            2'd1: begin
                if (elig[1])      gnt = 3'b010;
                else if (elig[2]) gnt = 3'b100;
                else if (elig[0]) gnt = 3'b001;
            end
            default: begin
                if (elig[2])      gnt = 3'b100;
                else if (elig[0]) gnt = 3'b001;
                else if (elig[1]) gnt = 3'b010;
            end
        endcase
    end

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        wr_gnt     = gnt[1:0];
        rd_gnt     = gnt[2];
        fifo_push  = |gnt[1:0];
        fifo_pop   = gnt[2];
        fifo_din   = '0;
        if (gnt[0])
            fifo_din = wr_data0;
        else if (gnt[1])
            fifo_din = wr_data1;

        case (state)
            IDLE:    if (gnt[2]) state_nxt = RD_WAIT;
            RD_WAIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (gnt[0])
            rr_ptr_nxt = 2'd1;
        else if (gnt[1])
            rr_ptr_nxt = 2'd2;
        else if (gnt[2])
            rr_ptr_nxt = 2'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= 2'd0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // Flag consistency is only meaningful in IDLE; during readout the controller is mid-update.
    assign flag_err = fifo_error ||
                      (state == IDLE && ((cnt_zero != fifo_empty) || (cnt_full != fifo_full)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            if (fifo_push)
                count <= count + CW'(1);
            else if (fifo_pop)
                count <= count - CW'(1);

            rd_valid <= (state == RD_WAIT);
            if (state == RD_WAIT)
                rd_data <= ram_q;

            if (flag_err)
                err_sticky <= 1'b1;
            else if (err_clr)
                err_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_share_sched.sv
// Directed bench for fifo_share_sched: emulated FIFO controller, queue-based reference model, literal pins.
module tb_fifo_share_sched;
    localparam int DEPTH = 64;
    localparam int DW    = 16;
    localparam int CW    = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    wr_req;
    logic [DW-1:0] wr_data0, wr_data1;
    logic [1:0]    wr_gnt;
    logic          rd_req, rd_gnt;
    logic [DW-1:0] rd_data;
    logic          rd_valid, fifo_push, fifo_pop;
    logic [DW-1:0] fifo_din;
    logic          fifo_empty, fifo_full, fifo_error;
    logic [DW-1:0] ram_q;
    logic [CW-1:0] count;
    logic          err_clr, err_sticky;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fifo_share_sched #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_valid(rd_valid),
        .fifo_push(fifo_push), .fifo_pop(fifo_pop), .fifo_din(fifo_din),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_error(fifo_error),
        .ram_q(ram_q), .count(count), .err_clr(err_clr), .err_sticky(err_sticky)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tmo(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event not seen within bound, required it to occur", name);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Emulated FIFO controller: push/pop take effect at the edge, popped word appears on ram_q next cycle.
    logic [DW-1:0] ctl_q[$];
    int            ctl_n;
    logic          empty_flip;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ctl_q.delete();
            ctl_n <= 0;
            ram_q <= '0;
        end else begin
            if (fifo_push) begin
                ctl_q.push_back(fifo_din);
                ctl_n <= ctl_n + 1;
            end
            if (fifo_pop && ctl_q.size() > 0) begin
                ram_q <= ctl_q.pop_front();
                ctl_n <= ctl_n - 1;
            end
        end
    end

    assign fifo_empty = (ctl_n == 0) ^ empty_flip;
    assign fifo_full  = (ctl_n == DEPTH);

    // Reference model: occupancy, pointer, readout pipeline and expected data order.
    int            m_cnt, m_ptr;
    bit            m_busy, m_rdv, m_err;
    logic [DW-1:0] m_rdd, m_pend;
    logic [DW-1:0] m_q[$];
    int            glog[$];
    bit            log_en = 1'b0;
    int            wr_gnt_seen = 0;
    int            rd_gnt_seen = 0;

    always @(negedge clk) begin
        bit [2:0]      el;
        int            g, idx;
        logic [1:0]    e_wg;
        logic [DW-1:0] e_din;
        bit            nerr;
        if (rst) begin
            chk("rst_wr_gnt", wr_gnt, 0);
            chk("rst_rd_gnt", rd_gnt, 0);
            chk("rst_push", fifo_push, 0);
            chk("rst_pop", fifo_pop, 0);
            chk("rst_din", fifo_din, 0);
            chk("rst_count", count, 0);
            chk("rst_rd_valid", rd_valid, 0);
            chk("rst_rd_data", rd_data, 0);
            chk("rst_err", err_sticky, 0);
            m_cnt = 0; m_ptr = 0; m_busy = 0; m_rdv = 0; m_err = 0;
            m_rdd = '0; m_pend = '0; m_q.delete();
        end else begin
            el[0] = !m_busy && wr_req[0] && !fifo_full && m_cnt < DEPTH;
            el[1] = !m_busy && wr_req[1] && !fifo_full && m_cnt < DEPTH;
            el[2] = !m_busy && rd_req && !fifo_empty && m_cnt > 0;
            g = -1;
            for (int k = 0; k < 3; k++) begin
                idx = (m_ptr + k) % 3;
                if (g < 0 && el[idx]) g = idx;
            end
            e_wg  = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
            e_din = (g == 0) ? wr_data0 : (g == 1) ? wr_data1 : '0;

            chk("wr_gnt", wr_gnt, e_wg);
            chk("rd_gnt", rd_gnt, g == 2);
            chk("fifo_push", fifo_push, g == 0 || g == 1);
            chk("fifo_pop", fifo_pop, g == 2);
            chk("fifo_din", fifo_din, e_din);
            chk("count", count, m_cnt);
            chk("rd_valid", rd_valid, m_rdv);
            chk("rd_data", rd_data, m_rdd);
            chk("err_sticky", err_sticky, m_err);

            if (wr_gnt != 0) wr_gnt_seen++;
            if (rd_gnt) rd_gnt_seen++;
            if (log_en) glog.push_back(g);

            nerr = fifo_error || (!m_busy && (((m_cnt == 0) != fifo_empty) ||
                                              ((m_cnt == DEPTH) != fifo_full)));
            if (nerr) m_err = 1;
            else if (err_clr) m_err = 0;

            m_rdv = m_busy;
            if (m_busy) m_rdd = m_pend;
            if (g >= 0) m_ptr = (g + 1) % 3;
            if (g == 0 || g == 1) begin
                m_q.push_back(e_din);
                m_cnt++;
            end
            m_busy = (g == 2);
            if (g == 2) begin
                m_pend = m_q.pop_front();
                m_cnt--;
            end
        end
    end

    task automatic wait_rd_gnt(input string name);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rd_gnt) seen = 1;
        end
        if (!seen) tmo(name);
    endtask

    initial begin
        int base;
        int exp_seq[8];
        rst = 1; wr_req = 0; wr_data0 = 0; wr_data1 = 0; rd_req = 0;
        fifo_error = 0; err_clr = 0; empty_flip = 0;
        cyc(3);
        rst = 0;

        // Three back-to-back pushes from writer 0.
        base = wr_gnt_seen;
        wr_req = 2'b01; wr_data0 = 16'hA5A5;
        cyc(3);
        wr_req = 2'b00;
        @(negedge clk);
        chk("t1_count", count, 3);
        chk("t1_gnts", wr_gnt_seen - base, 3);

        // One push from writer 1 leaves 4 words, pointer at reader; then everyone contends.
        @(posedge clk); #1;
        wr_req = 2'b10; wr_data1 = 16'h5A5A;
        cyc(1);
        wr_req = 2'b11; wr_data0 = 16'h1111; wr_data1 = 16'h2222; rd_req = 1; log_en = 1;
        cyc(8);
        log_en = 0; wr_req = 2'b00; rd_req = 0;
        exp_seq = '{2, -1, 0, 1, 2, -1, 0, 1};
        if (glog.size() != 8) tmo("t2_log_len");
        else for (int i = 0; i < 8; i++) chk($sformatf("t2_order%0d", i), glog[i], exp_seq[i]);
        cyc(3);

        // Fill to capacity, then both writers must stall until a pop frees one slot.
        wr_req = 2'b01; wr_data0 = 16'h0F0F;
        for (int i = 0; i < 120 && count != CW'(DEPTH); i++) cyc(1);
        if (count != CW'(DEPTH)) tmo("t3_fill");
        wr_req = 2'b11;
        base = wr_gnt_seen;
        cyc(4);
        chk("t3_full_gnts", wr_gnt_seen - base, 0);
        chk("t3_full_flag", fifo_full, 1);
        chk("t3_full_count", count, DEPTH);
        rd_req = 1;
        wait_rd_gnt("t3_pop");
        @(posedge clk); #1;
        rd_req = 0;
        base = wr_gnt_seen;
        cyc(6);
        chk("t3_one_push", wr_gnt_seen - base, 1);
        chk("t3_refill", count, DEPTH);
        wr_req = 2'b00;

        rst = 1;
        cyc(2);
        rst = 0;

        // Single word round trip, then reading an empty FIFO.
        wr_req = 2'b01; wr_data0 = 16'h1234;
        cyc(1);
        wr_req = 2'b00; rd_req = 1;
        wait_rd_gnt("t4_pop");
        @(negedge clk);
        chk("t4_t1_rd_gnt", rd_gnt, 0);
        chk("t4_t1_wr_gnt", wr_gnt, 0);
        @(negedge clk);
        chk("t4_valid", rd_valid, 1);
        chk("t4_data", rd_data, 16'h1234);
        chk("t4_count", count, 0);
        base = rd_gnt_seen;
        cyc(4);
        chk("t4_empty_gnts", rd_gnt_seen - base, 0);
        rd_req = 0;

        // Reset while in the readout cycle.
        wr_req = 2'b01; wr_data0 = 16'h0001;
        cyc(2);
        wr_req = 2'b00; rd_req = 1;
        wait_rd_gnt("t5_pop");
        @(posedge clk); #1;
        rst = 1; rd_req = 0;
        @(negedge clk);
        chk("t5_count", count, 0);
        chk("t5_valid", rd_valid, 0);
        @(posedge clk); #1;
        rst = 0;
        cyc(2);
        wr_req = 2'b11; wr_data0 = 16'hCAFE; wr_data1 = 16'hBEEF;
        @(negedge clk);
        chk("t5_ptr0", wr_gnt, 2'b01);
        @(posedge clk); #1;
        wr_req = 2'b00;

        // Sticky error: set, hold, clear, set-over-clear, and a flag mismatch.
        fifo_error = 1;
        cyc(1);
        fifo_error = 0;
        @(negedge clk);
        chk("t6_set", err_sticky, 1);
        cyc(3);
        chk("t6_hold", err_sticky, 1);
        err_clr = 1;
        cyc(1);
        err_clr = 0;
        @(negedge clk);
        chk("t6_clr", err_sticky, 0);
        @(posedge clk); #1;
        fifo_error = 1; err_clr = 1;
        cyc(1);
        fifo_error = 0; err_clr = 0;
        @(negedge clk);
        chk("t6_set_prio", err_sticky, 1);
        @(posedge clk); #1;
        err_clr = 1;
        cyc(1);
        err_clr = 0; empty_flip = 1;
        cyc(1);
        empty_flip = 0;
        @(negedge clk);
        chk("t6_flag_mismatch", err_sticky, 1);
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_share_sched.md
Name: fifo_share_sched

Overview:
- Scheduler that shares the 64x16 FIFO (FIFO controller plus its RAM) between two writer clients and one reader client.
- Arbitrates push and pop requests round-robin and drives the controller's push/pop inputs.
- Never issues a command the controller would flag as an error: no push/pop in the same cycle, no command during a readout cycle, no push when full, no pop when empty.
- Steers write data to the RAM and returns read data to the reader with a valid pulse.

Parameters:
- DEPTH, 64, FIFO capacity in words
- DW, 16, data width
- CW, 7, occupancy counter width (holds 0..DEPTH)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wr_req  in  2  per-writer push request; level, held until granted
- wr_data0  in  DW  writer 0 data
- wr_data1  in  DW  writer 1 data
- wr_gnt  out  2  one-cycle grant; data is taken in the grant cycle
- rd_req  in  1  reader pop request; level, held until granted
- rd_gnt  out  1  one-cycle pop grant
- rd_data  out  DW  registered read data
- rd_valid  out  1  one-cycle pulse, rd_data valid
- fifo_push  out  1  to controller push
- fifo_pop  out  1  to controller pop
- fifo_din  out  DW  to RAM data input
- fifo_empty  in  1  controller empty flag
- fifo_full  in  1  controller full flag
- fifo_error  in  1  controller error flag
- ram_q  in  DW  RAM read data
- count  out  CW  scheduler's occupancy count
- err_clr  in  1  clears err_sticky
- err_sticky  out  1  set by fifo_error or a count/flag mismatch

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0 (writer 0), count=0, rd_data=0, rd_valid=0, err_sticky=0.
- While rst is high, all combinational outputs are 0: wr_gnt, rd_gnt, fifo_push, fifo_pop, fifo_din.
- States:
  - IDLE: grants allowed.
  - RD_WAIT: the controller is in its readout cycle; no grants.
- Eligibility, evaluated in IDLE only:
  - Writer i is eligible when wr_req[i] && !fifo_full && count<DEPTH.
  - Reader is eligible when rd_req && !fifo_empty && count!=0.
- Arbitration:
  - Requester order is 0=wr0, 1=wr1, 2=rd.
  - Grant the first eligible requester starting at rr_ptr, wrapping 2->0.
  - On a grant, rr_ptr <= (grantee+1) mod 3.
  - With no grant, rr_ptr holds.
  - At most one grant per cycle.
- Push grant to writer i (combinational, same cycle):
  - wr_gnt[i]=1, fifo_push=1, fifo_din=wr_data_i.
  - Next cycle: count+1; state stays IDLE, so back-to-back pushes are allowed.
- Pop grant at cycle T:
  - Cycle T: rd_gnt=1, fifo_pop=1. Next state RD_WAIT; count-1 at T+1.
  - Cycle T+1: RD_WAIT, all grants 0, ram_q sampled into rd_data at end of cycle.
  - Cycle T+2: rd_valid=1, state IDLE, new grants allowed. Minimum pop-to-pop spacing is 2 cycles.
- fifo_din is 0 when there is no push grant. fifo_push and fifo_pop are never both 1.
- Boundaries:
  - Full (count==DEPTH or fifo_full): writers are blocked and the reader is still served.
  - Empty: the reader is blocked.
  - Writer requests during RD_WAIT wait one cycle.
  - count saturates logically at DEPTH by eligibility and never wraps.
- err_sticky is set on any cycle with:
  - fifo_error=1; or
  - (count==0) != fifo_empty in IDLE; or
  - (count==DEPTH) != fifo_full in IDLE.
- err_sticky is cleared by err_clr; set has priority over clear in the same cycle.
- Reset mid-operation: from RD_WAIT, return to IDLE with no rd_valid. The pending word is discarded and count=0. The controller is reset by the same event.

Test Plan:
- Reset, then wr_req=2'b01 with wr_data0=16'hA5A5 for 3 cycles -> wr_gnt[0] and fifo_push in 3 consecutive cycles, fifo_din=16'hA5A5, count 0->3.
- Both writers plus the reader requesting continuously, FIFO holding 4 words -> grant order wr0, wr1, rd (2-cycle gap), wr0, ...; no cycle with fifo_push and fifo_pop both 1.
- 64 pushes, then wr_req=2'b11 -> no wr_gnt while count=64 and fifo_full=1; a pop grant then unblocks exactly one push.
- Push 16'h1234, then rd_req -> rd_gnt at T, no grants at T+1, rd_valid=1 and rd_data=16'h1234 at T+2, count=0, rd_req with empty gives no further grants.
- Assert rst in RD_WAIT -> count=0, rd_valid stays 0, state IDLE, rr_ptr=0.
- Force fifo_error=1 for one cycle -> err_sticky=1 and it holds; err_clr=1 -> err_sticky=0 next cycle.
